pheap_level: RTL and testbench

Generic inner/leaf level stage of the pHeap pipelined heap priority queue (max-heap). It sits below the root level, or below another `pheap_level`, and accepts the `NEXT_LEVEL` handoff from the level above: a value, an operation and a node position. It then completes that operation on its own node memory, using the children read from the level below, and hands the residual work downward. It also serves the read port that the level above uses to inspect this level's nodes as children.

---
 rtl/pheap_level.sv | 231 +++++++++++++++++++++++
 tb/tb_pheap_level.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pheap_level.sv
// pheap_level: inner/leaf stage of the pipelined max-heap.
// Accepts a handoff (value, op, node) from the level above, finishes the
// operation on its own node memory using the children read from the level
// below, and hands the residual work further down. Also serves the child
// read port used by the level above.

package pheap_types;
   localparam int PHEAP_LEVELS = 3;
   localparam int KEY_W        = 8;
   localparam int VAL_W        = 8;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [VAL_W-1:0] value;
   } kv_t;

   localparam kv_t KV_EMPTY = '0;

   typedef struct packed {
      kv_t                     kv;
      logic [PHEAP_LEVELS-1:0] capacity;
      logic                    active;
   } entry_t;

   typedef enum logic [1:0] {LEQ = 2'd0, DEQ = 2'd1, ENQ_DEQ = 2'd2} opcode_t;
   typedef enum logic [1:0] {DONE = 2'd0, WAIT = 2'd1, NEXT_LEVEL = 2'd2} done_t;
endpackage

module pheap_level
   import pheap_types::*;
#(
   parameter int LEVELS = 3,
   parameter int LEVEL  = 2,
   parameter int LAST   = 0,
   localparam int AW    = LEVEL - 1,
   localparam int PW    = (LEVEL > 2) ? LEVEL - 2 : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  opcode_t       op,
   input  kv_t           in,
   input  logic [AW-1:0] pos,
   input  logic [PW-1:0] rParentIdx,
   output entry_t        rTopL,
   output entry_t        rTopR,
   output logic [AW-1:0] raddrBot,
   input  entry_t        rBotL,
   input  entry_t        rBotR,
   output done_t         done,
   output logic          startOut,
   output opcode_t       opOut,
   output kv_t           out,
   output logic [AW-1:0] posOut,
   output logic          endPos
);

   localparam int CW = PHEAP_LEVELS;
   localparam int N  = 1 << AW;
   localparam logic [CW-1:0] CAP_ONE   = CW'(1);
   localparam logic [CW-1:0] RESET_CAP = CW'((1 << (LEVELS - LEVEL + 1)) - 1);
   localparam entry_t RESET_ENTRY = '{kv: KV_EMPTY, capacity: RESET_CAP, active: 1'b0};

   typedef enum logic {IDLE = 1'b0, SET_OUT = 1'b1} state_t;

   state_t        state_reg;
   opcode_t       op_reg;
   kv_t           in_reg;
   logic [AW-1:0] pos_reg;
   entry_t        mem_reg [N];

   entry_t        node;
   entry_t        child_l;
   entry_t        child_r;
   logic          best_sel;
   logic          best_valid;
   kv_t           best_kv;
   logic          wr_en;
   entry_t        wr_entry;
   logic [AW-1:0] top_l_idx;
   logic [AW-1:0] top_r_idx;

   assign node     = mem_reg[pos_reg];
   assign raddrBot = pos_reg;
   assign posOut   = pos_reg;
   assign rTopL    = mem_reg[top_l_idx];
   assign rTopR    = mem_reg[top_r_idx];

   // The first inner level has only two nodes, so the parent index carries no information.
   generate
      if (LEVEL == 2) begin : g_top_first
         logic unused_parent;
         assign unused_parent = ^rParentIdx;
         assign top_l_idx     = AW'(0);
         assign top_r_idx     = AW'(1);
      end else begin : g_top_inner
         assign top_l_idx = {rParentIdx, 1'b0};
         assign top_r_idx = {rParentIdx, 1'b1};
      end
   endgenerate

   // The bottom level has no children below it: treat both as empty.
   generate
      if (LAST != 0) begin : g_leaf
         entry_t unused_bot;
         assign unused_bot = rBotL ^ rBotR;
         assign child_l    = RESET_ENTRY;
         assign child_r    = RESET_ENTRY;
      end else begin : g_inner
         assign child_l = rBotL;
         assign child_r = rBotR;
      end
   endgenerate

   // Pick the larger active child; left wins ties, inactive loses to anything.
   always_comb begin
      best_valid = child_l.active | child_r.active;
      if (child_l.active && child_r.active) begin
         best_sel = (child_r.kv.key > child_l.kv.key);
      end else begin
         best_sel = child_r.active;
      end
      best_kv = best_sel ? child_r.kv : child_l.kv;
   end

   // Per-operation decision in SET_OUT: node update and work handed downward.
   always_comb begin
      wr_en    = 1'b0;
      wr_entry = node;
      done     = DONE;
      startOut = 1'b0;
      opOut    = LEQ;
      out      = KV_EMPTY;
      endPos   = 1'b0;
      if (state_reg == IDLE) begin
         if (start && !rst) begin
            done = WAIT;
         end
      end else if (!rst) begin
         case (op_reg)
            LEQ: begin
               if (node.capacity == '0) begin
                  // Full subtree: upstream violation, element dropped.
                  wr_en = 1'b0;
               end else if (!node.active) begin
                  wr_en    = 1'b1;
                  wr_entry = '{kv: in_reg, capacity: node.capacity - CAP_ONE, active: 1'b1};
               end else begin
                  wr_en    = 1'b1;
                  // Incoming value sinks on a tie.
                  if (in_reg.key > node.kv.key) begin
                     wr_entry = '{kv: in_reg, capacity: node.capacity - CAP_ONE, active: 1'b1};
                     out      = node.kv;
                  end else begin
                     wr_entry = '{kv: node.kv, capacity: node.capacity - CAP_ONE, active: 1'b1};
                     out      = in_reg;
                  end
                  endPos   = (child_r.capacity > child_l.capacity);
                  startOut = 1'b1;
                  opOut    = LEQ;
                  done     = NEXT_LEVEL;
               end
            end
            DEQ: begin
               wr_en = 1'b1;
               if (!best_valid) begin
                  wr_entry = '{kv: KV_EMPTY, capacity: node.capacity + CAP_ONE, active: 1'b0};
               end else begin
                  wr_entry = '{kv: best_kv, capacity: node.capacity + CAP_ONE, active: 1'b1};
                  endPos   = best_sel;
                  startOut = 1'b1;
                  opOut    = DEQ;
                  done     = NEXT_LEVEL;
               end
            end
            ENQ_DEQ: begin
               wr_en = 1'b1;
               if (!best_valid || (in_reg.key >= best_kv.key)) begin
                  wr_entry = '{kv: in_reg, capacity: node.capacity, active: 1'b1};
               end else begin
                  wr_entry = '{kv: best_kv, capacity: node.capacity, active: 1'b1};
                  out      = in_reg;
                  endPos   = best_sel;
                  startOut = 1'b1;
                  opOut    = ENQ_DEQ;
                  done     = NEXT_LEVEL;
               end
            end
            default: begin
               wr_en = 1'b0;
            end
         endcase
      end
   end

   // Two-state FSM; handoff registers are captured only when accepting in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         op_reg    <= LEQ;
         in_reg    <= KV_EMPTY;
         pos_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  op_reg    <= op;
                  in_reg    <= in;
                  pos_reg   <= pos;
                  state_reg <= SET_OUT;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Node memory: reset restores empty nodes; the decision writes at the SET_OUT edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            mem_reg[i] <= RESET_ENTRY;
         end
      end else if (wr_en) begin
         mem_reg[pos_reg] <= wr_entry;
      end
   end

endmodule

// File: tb/tb_pheap_level.sv
// Directed and random checks of pheap_level (LEVELS=3, LEVEL=2, LAST=0)
// against a small reference model of the two-node level.
module tb_pheap_level;
   import pheap_types::*;

   logic    clk = 1'b0;
   logic    rst;
   logic    start;
   opcode_t op;
   kv_t     in;
   logic [0:0] pos;
   logic [0:0] rParentIdx;
   entry_t  rTopL, rTopR;
   logic [0:0] raddrBot;
   entry_t  rBotL, rBotR;
   done_t   done;
   logic    startOut;
   opcode_t opOut;
   kv_t     out;
   logic [0:0] posOut;
   logic    endPos;

   int errors = 0;
   int checks = 0;

   localparam entry_t RESET_ENTRY = '{kv: '0, capacity: 3'd3, active: 1'b0};
   entry_t model_mem [2];

   always #5 clk = ~clk;

   pheap_level #(.LEVELS(3), .LEVEL(2), .LAST(0)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .in(in), .pos(pos),
      .rParentIdx(rParentIdx), .rTopL(rTopL), .rTopR(rTopR), .raddrBot(raddrBot),
      .rBotL(rBotL), .rBotR(rBotR), .done(done), .startOut(startOut),
      .opOut(opOut), .out(out), .posOut(posOut), .endPos(endPos)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic kv_t mk(input int k, input int v);
      kv_t r;
      r.key   = k[7:0];
      r.value = v[7:0];
      return r;
   endfunction

   function automatic entry_t ent(input int k, input int v, input int c, input int a);
      entry_t e;
      e.kv       = mk(k, v);
      e.capacity = c[2:0];
      e.active   = a[0];
      return e;
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, "_topL"}, rTopL, model_mem[0]);
      chk({tag, "_topR"}, rTopR, model_mem[1]);
      chk({tag, "_done"}, done, DONE);
      chk({tag, "_start"}, startOut, 1'b0);
   endtask

   // One handoff: start cycle, SET_OUT cycle, then readback of the node memory.
   task automatic run_op(input opcode_t o, input kv_t v, input int p, input entry_t bl, input entry_t br);
      entry_t  t;
      entry_t  kids [2];
      int      best;
      kv_t     keep, down;
      done_t   e_done;
      logic    e_start;
      opcode_t e_op;
      kv_t     e_out;
      logic    e_end;

      start = 1'b1; op = o; in = v; pos = p[0]; rParentIdx = 1'($urandom_range(0, 1));
      #1;
      chk("done_wait", done, WAIT);
      @(posedge clk); #1;
      start = 1'b0; op = LEQ; in = '0;
      rBotL = bl; rBotR = br;
      #1;

      // Reference: node update and downward handoff from the operation rules.
      t = model_mem[p];
      kids[0] = bl; kids[1] = br;
      best = -1;
      for (int k = 0; k < 2; k++) begin
         if (kids[k].active && (best < 0 || kids[k].kv.key > kids[best].kv.key)) best = k;
      end
      e_done = DONE; e_start = 1'b0; e_op = LEQ; e_out = '0; e_end = 1'b0;
      case (o)
         LEQ: begin
            if (t.capacity == 3'd0) begin
               e_done = DONE;
            end else if (!t.active) begin
               model_mem[p] = '{kv: v, capacity: t.capacity - 3'd1, active: 1'b1};
            end else begin
               if (v.key > t.kv.key) begin keep = v; down = t.kv; end
               else begin keep = t.kv; down = v; end
               model_mem[p] = '{kv: keep, capacity: t.capacity - 3'd1, active: 1'b1};
               e_out = down; e_end = (br.capacity > bl.capacity);
               e_start = 1'b1; e_op = LEQ; e_done = NEXT_LEVEL;
            end
         end
         DEQ: begin
            if (best < 0) begin
               model_mem[p] = '{kv: '0, capacity: t.capacity + 3'd1, active: 1'b0};
            end else begin
               model_mem[p] = '{kv: kids[best].kv, capacity: t.capacity + 3'd1, active: 1'b1};
               e_end = (best == 1); e_start = 1'b1; e_op = DEQ; e_done = NEXT_LEVEL;
            end
         end
         default: begin
            if (best < 0 || v.key >= kids[best].kv.key) begin
               model_mem[p] = '{kv: v, capacity: t.capacity, active: 1'b1};
            end else begin
               model_mem[p] = '{kv: kids[best].kv, capacity: t.capacity, active: 1'b1};
               e_out = v; e_end = (best == 1); e_start = 1'b1; e_op = ENQ_DEQ; e_done = NEXT_LEVEL;
            end
         end
      endcase

      chk("set_done", done, e_done);
      chk("set_startOut", startOut, e_start);
      chk("set_opOut", opOut, e_op);
      chk("set_out", out, e_out);
      chk("set_endPos", endPos, e_end);
      chk("set_posOut", posOut, p[0]);
      chk("set_raddrBot", raddrBot, p[0]);
      $display("op=%s pos=%0d in=%0d/%0d botL=%h botR=%h -> done=%s startOut=%0d out=%0d endPos=%0d node=%h",
               o.name(), p, v.key, v.value, bl, br, done.name(), startOut, out.key, endPos, model_mem[p]);

      @(posedge clk); #1;
      rBotL = RESET_ENTRY; rBotR = RESET_ENTRY;
      check_idle("after");
   endtask

   initial begin
      opcode_t ro;
      int      rp;
      entry_t  bl, br;

      rst = 1'b1; start = 1'b0; op = LEQ; in = '0; pos = '0; rParentIdx = '0;
      rBotL = RESET_ENTRY; rBotR = RESET_ENTRY;
      model_mem[0] = RESET_ENTRY; model_mem[1] = RESET_ENTRY;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check_idle("reset");
      chk("reset_out", out, '0);
      chk("reset_opOut", opOut, LEQ);
      chk("reset_posOut", posOut, 1'b0);
      chk("reset_raddrBot", raddrBot, 1'b0);
      chk("reset_endPos", endPos, 1'b0);
      @(posedge clk); #1;

      // Directed steps
      run_op(LEQ, mk(5, 1), 0, ent(0, 0, 1, 0), ent(0, 0, 1, 0));
      run_op(LEQ, mk(9, 2), 0, ent(0, 0, 1, 0), ent(0, 0, 1, 0));
      run_op(DEQ, mk(0, 0), 0, ent(7, 3, 0, 1), ent(8, 4, 1, 1));
      run_op(DEQ, mk(0, 0), 0, ent(1, 1, 1, 0), ent(2, 2, 1, 0));
      run_op(LEQ, mk(4, 5), 1, ent(0, 0, 1, 0), ent(0, 0, 1, 0));
      run_op(LEQ, mk(3, 6), 1, ent(0, 0, 1, 0), ent(0, 0, 0, 0));
      run_op(ENQ_DEQ, mk(6, 7), 1, ent(3, 8, 0, 1), ent(9, 9, 1, 0));
      run_op(ENQ_DEQ, mk(2, 10), 1, ent(3, 11, 0, 1), ent(1, 12, 1, 1));
      run_op(ENQ_DEQ, mk(3, 13), 1, ent(3, 14, 0, 1), ent(3, 15, 1, 1));
      run_op(DEQ, mk(0, 0), 1, ent(6, 16, 0, 1), ent(6, 17, 1, 1));
      run_op(LEQ, mk(2, 18), 0, ent(0, 0, 0, 0), ent(0, 0, 1, 0));
      run_op(LEQ, mk(2, 19), 0, ent(0, 0, 1, 0), ent(0, 0, 1, 0));
      run_op(LEQ, mk(7, 20), 0, ent(0, 0, 0, 0), ent(0, 0, 0, 0));
      run_op(LEQ, mk(8, 21), 0, ent(0, 0, 1, 0), ent(0, 0, 0, 0));

      // Reset asserted while the level is in SET_OUT of an LEQ
      start = 1'b1; op = LEQ; in = mk(10, 22); pos = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; rst = 1'b1;
      #1;
      chk("rst_set_startOut", startOut, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_mem[0] = RESET_ENTRY; model_mem[1] = RESET_ENTRY;
      #1;
      check_idle("rst_set");
      $display("op=LEQ pos=1 with rst in SET_OUT -> done=%s startOut=%0d", done.name(), startOut);

      // Random operations against the model
      for (int n = 0; n < 150; n++) begin
         rp = int'($urandom_range(0, 1));
         case ($urandom_range(0, 2))
            0: ro = LEQ;
            1: ro = DEQ;
            default: ro = ENQ_DEQ;
         endcase
         if (ro == DEQ && model_mem[rp].capacity >= 3'd3) ro = LEQ;
         bl = ent(int'($urandom_range(1, 12)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
         br = ent(int'($urandom_range(1, 12)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
         run_op(ro, mk(int'($urandom_range(1, 12)), int'($urandom_range(0, 255))), rp, bl, br);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
